mem_access: RTL and testbench

Memory-stage data access unit: consumes the effective address and memory opcode produced by the execute-stage ALU and drives the data SRAM-like bus. It generates byte strobes and lane-replicated store data, runs the request/address-ack/data-ack handshake, and stalls the pipeline while an access is outstanding. It returns sign- or zero-extended load data to the write-back path and drains accesses that are flushed mid-flight.

---
 rtl/mem_access_pkg.sv | 33 +++
 rtl/mem_load_ext.sv | 33 +++
 rtl/mem_access.sv | 130 +++++++++++++
 tb/tb_mem_access.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings for the memory-stage access unit
package mem_access_pkg;

    typedef enum logic [2:0] {
        MEM_IDLE,
        MEM_WAIT_ADDR,
        MEM_WAIT_DATA,
        MEM_DONE,
        MEM_CANCEL
    } mem_state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    function automatic logic is_mem_op(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// rtl/mem_load_ext.sv - lane select and sign/zero extension of a raw read word
module mem_load_ext
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [7:0]  memop,
    output logic [31:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        case (addr_lo)
            2'd0:    sel_byte = rdata[7:0];
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            default: sel_byte = rdata[31:24];
        endcase
        sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (memop)
            EXE_LB_OP:  result = {{24{sel_byte[7]}}, sel_byte};
            EXE_LBU_OP: result = {24'd0, sel_byte};
            EXE_LH_OP:  result = {{16{sel_half[15]}}, sel_half};
            EXE_LHU_OP: result = {16'd0, sel_half};
            EXE_LW_OP:  result = rdata;
            default:    result = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-stage bus access FSM with strobes, stall and load return
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  memopM,
    input  logic [31:0] addrM,
    input  logic [31:0] wdataM,
    input  logic        excM,
    input  logic        flushM,
    input  logic        stall_in,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        mem_stall,
    output logic [31:0] load_dataM
);

    mem_state_t  state;
    logic [31:0] saved_data;
    logic [31:0] ext_data;
    logic        start;

    assign start     = is_mem_op(memopM) & ~excM & ~flushM;
    assign data_addr = addrM;

    mem_load_ext u_load_ext (
        .rdata   (data_rdata),
        .addr_lo (addrM[1:0]),
        .memop   (memopM),
        .result  (ext_data)
    );

    always_comb begin
        data_wr    = 1'b0;
        data_size  = SIZE_W;
        data_wstrb = 4'b0000;
        data_wdata = wdataM;
        case (memopM)
            EXE_LB_OP, EXE_LBU_OP: data_size = SIZE_B;
            EXE_LH_OP, EXE_LHU_OP: data_size = SIZE_H;
            EXE_SB_OP: begin
                data_wr    = 1'b1;
                data_size  = SIZE_B;
                data_wstrb = 4'b0001 << addrM[1:0];
                data_wdata = {4{wdataM[7:0]}};
            end
            EXE_SH_OP: begin
                data_wr    = 1'b1;
                data_size  = SIZE_H;
                data_wstrb = addrM[1] ? 4'b1100 : 4'b0011;
                data_wdata = {2{wdataM[15:0]}};
            end
            EXE_SW_OP: begin
                data_wr    = 1'b1;
                data_wstrb = 4'b1111;
            end
            default: ;
        endcase
    end

    // Request and stall are Mealy outputs so a zero-wait access costs no extra cycle.
    always_comb begin
        data_req   = 1'b0;
        mem_stall  = 1'b0;
        load_dataM = 32'd0;
        case (state)
            MEM_IDLE: begin
                data_req  = start;
                mem_stall = start;
            end
            MEM_WAIT_ADDR: begin
                data_req  = ~flushM;
                mem_stall = 1'b1;
            end
            MEM_WAIT_DATA: begin
                mem_stall = ~data_data_ok;
                if (data_data_ok)
                    load_dataM = ext_data;
            end
            MEM_DONE:   load_dataM = saved_data;
            MEM_CANCEL: mem_stall  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= MEM_IDLE;
            saved_data <= 32'd0;
        end else begin
            case (state)
                MEM_IDLE:
                    if (start)
                        state <= data_addr_ok ? MEM_WAIT_DATA : MEM_WAIT_ADDR;
                MEM_WAIT_ADDR:
                    if (flushM)
                        state <= MEM_IDLE;
                    else if (data_addr_ok)
                        state <= MEM_WAIT_DATA;
                MEM_WAIT_DATA:
                    if (data_data_ok) begin
                        if (stall_in && !flushM) begin
                            saved_data <= ext_data;
                            state      <= MEM_DONE;
                        end else begin
                            state <= MEM_IDLE;
                        end
                    end else if (flushM) begin
                        state <= MEM_CANCEL;
                    end
                MEM_DONE:
                    if (!stall_in || flushM)
                        state <= MEM_IDLE;
                MEM_CANCEL:
                    if (data_data_ok)
                        state <= MEM_IDLE;
                default: state <= MEM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  memopM;
    logic [31:0] addrM, wdataM;
    logic        excM, flushM, stall_in;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_stall;
    logic [31:0] load_dataM;

    int checks   = 0;
    int failures = 0;
    int req_cycles;

    always #5 clk = ~clk;

    mem_access dut (
        .clk          (clk),
        .rst          (rst),
        .memopM       (memopM),
        .addrM        (addrM),
        .wdataM       (wdataM),
        .excM         (excM),
        .flushM       (flushM),
        .stall_in     (stall_in),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_stall    (mem_stall),
        .load_dataM   (load_dataM)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock, then leave a small gap so inputs change away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        memopM = 8'd0; addrM = 32'd0; wdataM = 32'd0;
        excM = 1'b0; flushM = 1'b0; stall_in = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    endtask

    // Zero-wait load: req+addr_ok in one cycle, data_ok the next; checks returned data.
    task automatic quick_load(input string tag, input logic [7:0] op, input logic [31:0] addr,
                              input logic [31:0] rdata, input logic [31:0] exp);
        step(); memopM = op; addrM = addr; data_addr_ok = 1'b1; #1;
        check({tag, "_req"}, {31'd0, data_req}, 32'd1);
        step(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rdata; #1;
        check({tag, "_data"}, load_dataM, exp);
        step(); idle_inputs(); #1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #12;
        check("rst_req",   {31'd0, data_req},  32'd0);
        check("rst_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_load",  load_dataM,         32'd0);
        rst = 1'b0;

        // LW, minimum two-cycle access
        step(); memopM = EXE_LW_OP; addrM = 32'h8000_0010; data_addr_ok = 1'b1; #1;
        check("lw_req",   {31'd0, data_req},  32'd1);
        check("lw_size",  {30'd0, data_size}, 32'd2);
        check("lw_wstrb", {28'd0, data_wstrb}, 32'd0);
        check("lw_stall0", {31'd0, mem_stall}, 32'd1);
        check("lw_addr",  data_addr, 32'h8000_0010);
        step(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678; #1;
        check("lw_stall1", {31'd0, mem_stall}, 32'd0);
        check("lw_req1",  {31'd0, data_req},  32'd0);
        check("lw_data",  load_dataM, 32'h1234_5678);
        step(); idle_inputs(); #1;
        check("lw_idle_stall", {31'd0, mem_stall}, 32'd0);

        // SB with three wait cycles before addr_ok
        req_cycles = 0;
        step(); memopM = EXE_SB_OP; addrM = 32'h0000_1003; wdataM = 32'h0000_00AB; #1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) data_addr_ok = 1'b1;
            #1;
            if (data_req) req_cycles++;
            check("sb_stall", {31'd0, mem_stall}, 32'd1);
            if (i < 3) step();
        end
        check("sb_req_cycles", req_cycles, 32'd4);
        check("sb_wstrb", {28'd0, data_wstrb}, 32'h8);
        check("sb_wdata", data_wdata, 32'hABAB_ABAB);
        check("sb_wr",    {31'd0, data_wr}, 32'd1);
        check("sb_size",  {30'd0, data_size}, 32'd0);
        step(); data_addr_ok = 1'b0; data_data_ok = 1'b1; #1;
        check("sb_done_stall", {31'd0, mem_stall}, 32'd0);
        step(); idle_inputs(); #1;

        // Byte loads with sign and zero extension
        quick_load("lb",  EXE_LB_OP,  32'h0000_2002, 32'h0080_0000, 32'hFFFF_FF80);
        quick_load("lbu", EXE_LBU_OP, 32'h0000_2002, 32'h0080_0000, 32'h0000_0080);

        // LH with data_ok while a later stage stalls for two cycles
        step(); memopM = EXE_LH_OP; addrM = 32'h0000_3002; data_addr_ok = 1'b1; #1;
        step(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hABCD_1234;
        stall_in = 1'b1; #1;
        check("lh_data",  load_dataM, 32'hFFFF_ABCD);
        step(); data_data_ok = 1'b0; data_rdata = 32'd0; #1;
        check("lh_done_data",  load_dataM, 32'hFFFF_ABCD);
        check("lh_done_req",   {31'd0, data_req},  32'd0);
        check("lh_done_stall", {31'd0, mem_stall}, 32'd0);
        step(); stall_in = 1'b0; #1;
        check("lh_done_hold", load_dataM, 32'hFFFF_ABCD);
        check("lh_done_req2", {31'd0, data_req}, 32'd0);
        step(); idle_inputs(); #1;
        check("lh_after_load", load_dataM, 32'd0);
        quick_load("lw_after_done", EXE_LW_OP, 32'h0000_0010, 32'h1122_3344, 32'h1122_3344);

        // Flush while waiting for data, then the late response is swallowed
        step(); memopM = EXE_LW_OP; addrM = 32'h0000_4000; data_addr_ok = 1'b1; #1;
        step(); data_addr_ok = 1'b0; flushM = 1'b1; #1;
        check("fl_stall", {31'd0, mem_stall}, 32'd1);
        check("fl_req",   {31'd0, data_req},  32'd0);
        step(); idle_inputs(); #1;
        check("cancel_stall", {31'd0, mem_stall}, 32'd1);
        check("cancel_req",   {31'd0, data_req},  32'd0);
        step(); data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; #1;
        check("cancel_discard", load_dataM, 32'd0);
        check("cancel_stall2", {31'd0, mem_stall}, 32'd1);
        quick_load("lw_after_cancel", EXE_LW_OP, 32'h0000_4004, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Exception suppresses a store
        step(); memopM = EXE_SW_OP; addrM = 32'h0000_5000; excM = 1'b1; #1;
        check("exc_req",   {31'd0, data_req},  32'd0);
        check("exc_stall", {31'd0, mem_stall}, 32'd0);

        // SH upper half strobes and replication
        step(); excM = 1'b0; memopM = EXE_SH_OP; addrM = 32'h0000_6002;
        wdataM = 32'h1234_BEEF; data_addr_ok = 1'b1; #1;
        check("sh_wstrb", {28'd0, data_wstrb}, 32'hC);
        check("sh_wdata", data_wdata, 32'hBEEF_BEEF);
        step(); data_addr_ok = 1'b0; data_data_ok = 1'b1; #1;
        check("sh_stall", {31'd0, mem_stall}, 32'd0);
        step(); idle_inputs(); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        failures++;
        $display("FAIL timeout: bench did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
